// File: rtl/mux_rr_reg_pkg.sv
// Shared constants and helpers for the registered round-robin / fixed-select mux.
package mux_rr_reg_pkg;

    localparam logic MUX_MODE_FIXED = 1'b0;
    localparam logic MUX_MODE_RR    = 1'b1;

    // Successor of a channel index with wrap at n-1.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_reg_if.sv
// Producer-side and consumer-side handshake bundle of mux_rr_reg.
interface mux_rr_reg_if #(
    parameter int WIDTH = 2,
    parameter int N     = 2,
    parameter int SELW  = 1
);
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module mux_rr_reg_rr_arbiter #(
    parameter int N    = 2,
    parameter int SELW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            grant_valid,
    output logic [SELW-1:0] grant_idx
);
    // Pass one covers ptr..N-1; pass two only matters when pass one found nothing,
    // so it yields the lowest requester below ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[i] && (SELW'(i) >= ptr)) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(i);
            end
        end
    end
endmodule

// File: rtl/mux_rr_reg.sv
// N-channel mux with fixed-select or round-robin grant into a single-entry output register.
module mux_rr_reg
    import mux_rr_reg_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int N     = 2,
    parameter int SELW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_reg_if.slave   bus
);
    logic [SELW-1:0]  ptr;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             fix_valid;
    logic             g_valid;
    logic [SELW-1:0]  g_idx;
    logic             g_req;
    logic [WIDTH-1:0] g_data;
    logic             can_accept;
    logic             xfer;

    mux_rr_reg_rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req         (bus.in_valid),
        .ptr         (ptr),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    assign fix_valid  = int'(bus.sel) < N;
    assign g_valid    = (bus.mode == MUX_MODE_RR) ? rr_valid : fix_valid;
    assign g_idx      = (bus.mode == MUX_MODE_RR) ? rr_idx   : bus.sel;
    assign can_accept = !bus.out_valid || bus.out_ready;

    always_comb begin
        g_req  = 1'b0;
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g_idx == SELW'(i)) begin
                g_req  = bus.in_valid[i];
                g_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready follows the grant, not valid, so fixed mode can show ready on an idle channel.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = g_valid && (g_idx == SELW'(i)) && can_accept && !rst;
        end
    end

    assign xfer = g_valid && g_req && can_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            ptr           <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= g_data;
                bus.out_chan  <= g_idx;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (xfer && bus.mode == MUX_MODE_RR) begin
                ptr <= SELW'(next_idx(int'(g_idx), N));
            end
        end
    end
endmodule
